// File: rtl/md_dump_pkg.sv
// ============================================================================
// Module      : md_dump_pkg
// Description : Shared sizes, FSM encoding and beat packing for the cache dump
//               readback path. MD_DUMP_TLAST_EN adds tlast to the beat type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_dump_pkg;

    localparam int PARTICLE_ID_WIDTH   = 8;
    localparam int NUM_SUB_PACKETS     = 4;
    localparam int NUM_INIT_STEPS      = 4;
    localparam int NUM_CELLS           = NUM_SUB_PACKETS * NUM_INIT_STEPS;
    localparam int INIT_STEP_WIDTH     = 2;
    localparam int OFFSET_WIDTH        = 27;
    localparam int OFFSET_STRUCT_WIDTH = 3 * OFFSET_WIDTH;
    localparam int ELEMENT_WIDTH       = 2;
    localparam int SUB_PACKET_WIDTH    = 128;
    localparam int AXIS_TDATA_WIDTH    = NUM_SUB_PACKETS * SUB_PACKET_WIDTH;

    localparam int DUMP_RD_LATENCY     = 2;
    localparam int DUMP_FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    typedef struct packed {
`ifdef MD_DUMP_TLAST_EN
        logic                        tlast;
`endif
        logic [AXIS_TDATA_WIDTH-1:0] tdata;
    } dump_beat_t;

    // Each coordinate gets its own 32-bit lane; unused lane bits stay zero.
    function automatic logic [SUB_PACKET_WIDTH-1:0] pack_sub(
        input logic [OFFSET_STRUCT_WIDTH-1:0] off,
        input logic [ELEMENT_WIDTH-1:0]       elem
    );
        logic [SUB_PACKET_WIDTH-1:0] r;
        r                        = '0;
        r[0  +: OFFSET_WIDTH]    = off[0              +: OFFSET_WIDTH];
        r[32 +: OFFSET_WIDTH]    = off[OFFSET_WIDTH   +: OFFSET_WIDTH];
        r[64 +: OFFSET_WIDTH]    = off[2*OFFSET_WIDTH +: OFFSET_WIDTH];
        r[96 +: ELEMENT_WIDTH]   = elem;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_dump_fifo.sv
// ============================================================================
// Module      : md_dump_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_dump_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push && (r_count != c_cnt_w'(DEPTH));
    assign w_pop   = i_pop  && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/md_dump.sv
// ============================================================================
// Module      : md_dump
// Description : Reads every cell cache back group by group and packs four
//               cells per AXIS beat. Define MD_DUMP_TLAST_EN for o_dump_tlast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_dump
    import md_dump_pkg::*;
#(
    parameter int RD_LATENCY = DUMP_RD_LATENCY,
    parameter int FIFO_DEPTH = DUMP_FIFO_DEPTH
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             i_dump_start,
    input  logic [PARTICLE_ID_WIDTH-1:0]                     i_dump_npc,
    output logic [PARTICLE_ID_WIDTH-1:0]                     o_dump_rd_addr,
    output logic [NUM_INIT_STEPS-1:0]                        o_dump_rd_en,
    input  logic [NUM_CELLS-1:0][OFFSET_STRUCT_WIDTH-1:0]    i_dump_data,
    input  logic [NUM_CELLS-1:0][ELEMENT_WIDTH-1:0]          i_dump_element,
    output logic [AXIS_TDATA_WIDTH-1:0]                      o_dump_tdata,
    output logic                                             o_dump_tvalid,
    input  logic                                             i_dump_tready,
`ifdef MD_DUMP_TLAST_EN
    output logic                                             o_dump_tlast,
`endif
    output logic [INIT_STEP_WIDTH-1:0]                       o_dump_step,
    output logic                                             o_dump_busy,
    output logic                                             o_dump_done
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH+1);
    localparam int c_inf_w = $clog2(RD_LATENCY+1);
    localparam int c_sum_w = $clog2(FIFO_DEPTH+RD_LATENCY+1);
    localparam int c_sub_w = $clog2(NUM_SUB_PACKETS);

    dump_state_t                  r_state;
    dump_state_t                  w_next;
    logic [PARTICLE_ID_WIDTH-1:0] r_npc;
    logic [PARTICLE_ID_WIDTH-1:0] r_addr;
    logic [INIT_STEP_WIDTH-1:0]   r_step;

    logic [RD_LATENCY-1:0]                      r_pipe_v;
    logic [RD_LATENCY-1:0][INIT_STEP_WIDTH-1:0] r_pipe_step;
`ifdef MD_DUMP_TLAST_EN
    logic [RD_LATENCY-1:0]                      r_pipe_last;
`endif

    logic               w_issue;
    logic               w_last_addr;
    logic               w_last_step;
    logic [c_inf_w-1:0] w_inflight;
    logic [c_sum_w-1:0] w_outstanding;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic               w_pop;
    dump_beat_t         w_push_beat;
    dump_beat_t         w_head_beat;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            w_inflight = w_inflight + c_inf_w'(r_pipe_v[k]);
        end
    end

    // Reads already issued plus beats queued must never exceed FIFO space.
    assign w_outstanding = c_sum_w'(w_fifo_count) + c_sum_w'(w_inflight);
    assign w_issue       = (r_state == READ) && (w_outstanding < c_sum_w'(FIFO_DEPTH));
    assign w_last_addr   = (r_addr == (r_npc - 1'b1));
    assign w_last_step   = (r_step == INIT_STEP_WIDTH'(NUM_INIT_STEPS-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_dump_start) w_next = (i_dump_npc == '0) ? DONE : READ;
            READ:    if (w_issue && w_last_addr && w_last_step) w_next = DRAIN;
            DRAIN:   if ((w_inflight == '0) && w_fifo_empty) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_dump_busy  = (r_state == READ) || (r_state == DRAIN);
        o_dump_done  = (r_state == DONE);
        o_dump_rd_en = w_issue ? (NUM_INIT_STEPS'(1) << r_step) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_npc  <= '0;
            r_addr <= '0;
            r_step <= '0;
        end else if ((r_state == IDLE) && i_dump_start) begin
            r_npc  <= i_dump_npc;
            r_addr <= '0;
            r_step <= '0;
        end else if (w_issue) begin
            if (w_last_addr) begin
                r_addr <= '0;
                r_step <= r_step + 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_dump_rd_addr = r_addr;
    assign o_dump_step    = r_step;

    // The step travels with each read so packing selects the cells that were read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v    <= '0;
            r_pipe_step <= '0;
`ifdef MD_DUMP_TLAST_EN
            r_pipe_last <= '0;
`endif
        end else begin
            r_pipe_v[0]    <= w_issue;
            r_pipe_step[0] <= r_step;
`ifdef MD_DUMP_TLAST_EN
            r_pipe_last[0] <= w_last_addr && w_last_step;
`endif
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pipe_v[k]    <= r_pipe_v[k-1];
                r_pipe_step[k] <= r_pipe_step[k-1];
`ifdef MD_DUMP_TLAST_EN
                r_pipe_last[k] <= r_pipe_last[k-1];
`endif
            end
        end
    end

    always_comb begin
        w_push_beat = '0;
        for (int i = 0; i < NUM_SUB_PACKETS; i++) begin
            w_push_beat.tdata[i*SUB_PACKET_WIDTH +: SUB_PACKET_WIDTH] =
                pack_sub(i_dump_data[{r_pipe_step[RD_LATENCY-1], c_sub_w'(i)}],
                         i_dump_element[{r_pipe_step[RD_LATENCY-1], c_sub_w'(i)}]);
        end
`ifdef MD_DUMP_TLAST_EN
        w_push_beat.tlast = r_pipe_last[RD_LATENCY-1];
`endif
    end

    assign w_pop = !w_fifo_empty && i_dump_tready;

    md_dump_fifo #(
        .WIDTH ($bits(dump_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pipe_v[RD_LATENCY-1]),
        .i_data  (w_push_beat),
        .i_pop   (w_pop),
        .o_data  (w_head_beat),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_dump_tvalid = !w_fifo_empty;
    assign o_dump_tdata  = w_head_beat.tdata;
`ifdef MD_DUMP_TLAST_EN
    assign o_dump_tlast  = w_head_beat.tlast;
`endif

endmodule

`default_nettype wire

// File: tb/tb_md_dump.sv
// ============================================================================
// Module      : tb_md_dump
// Description : Randomised scoreboard bench for md_dump against a cache model.
//               Build with MD_DUMP_TLAST_EN to also check o_dump_tlast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_dump;
    import md_dump_pkg::*;

    localparam int L = DUMP_RD_LATENCY;
    localparam int D = DUMP_FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [PARTICLE_ID_WIDTH-1:0] npc;
    logic [PARTICLE_ID_WIDTH-1:0] rd_addr;
    logic [NUM_INIT_STEPS-1:0] rd_en;
    logic [NUM_CELLS-1:0][OFFSET_STRUCT_WIDTH-1:0] cdata;
    logic [NUM_CELLS-1:0][ELEMENT_WIDTH-1:0] celem;
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic tvalid;
    logic tready;
    logic tlast;
    logic [INIT_STEP_WIDTH-1:0] step;
    logic busy;
    logic done;

    md_dump u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_dump_start   (start),
        .i_dump_npc     (npc),
        .o_dump_rd_addr (rd_addr),
        .o_dump_rd_en   (rd_en),
        .i_dump_data    (cdata),
        .i_dump_element (celem),
        .o_dump_tdata   (tdata),
        .o_dump_tvalid  (tvalid),
        .i_dump_tready  (tready),
`ifdef MD_DUMP_TLAST_EN
        .o_dump_tlast   (tlast),
`endif
        .o_dump_step    (step),
        .o_dump_busy    (busy),
        .o_dump_done    (done)
    );

`ifndef MD_DUMP_TLAST_EN
    assign tlast = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [AXIS_TDATA_WIDTH-1:0] d;
        logic                        last;
    } exp_t;

    exp_t exp_q[$];
    logic [OFFSET_STRUCT_WIDTH-1:0] mem_off [NUM_CELLS][8];
    logic [ELEMENT_WIDTH-1:0]       mem_el  [NUM_CELLS][8];
    logic [NUM_INIT_STEPS-1:0]      dly_en  [L];
    logic [PARTICLE_ID_WIDTH-1:0]   dly_addr[L];
    logic [OFFSET_STRUCT_WIDTH-1:0] junk_off;
    logic [ELEMENT_WIDTH-1:0]       junk_el;

    int tests = 0, fails = 0;
    int cyc = 0, issued = 0, accepted = 0, rd_idx = 0, rd_npc = 0;
    int done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, start_cyc = 0;
    bit rnd_ready = 0;

    // Cache model: registered read of RD_LATENCY cycles; disabled groups return noise.
    always @(posedge clk) begin
        dly_en[0]   <= rd_en;
        dly_addr[0] <= rd_addr;
        for (int k = 1; k < L; k++) begin
            dly_en[k]   <= dly_en[k-1];
            dly_addr[k] <= dly_addr[k-1];
        end
        junk_off <= OFFSET_STRUCT_WIDTH'({$urandom(), $urandom(), $urandom()});
        junk_el  <= ELEMENT_WIDTH'($urandom());
    end

    always_comb begin
        for (int c = 0; c < NUM_CELLS; c++) begin
            cdata[c] = junk_off;
            celem[c] = junk_el;
            if (dly_en[L-1][c/NUM_SUB_PACKETS]) begin
                cdata[c] = mem_off[c][dly_addr[L-1][2:0]];
                celem[c] = mem_el[c][dly_addr[L-1][2:0]];
            end
        end
    end

    function automatic logic [AXIS_TDATA_WIDTH-1:0] exp_beat(input int s, input int a);
        logic [AXIS_TDATA_WIDTH-1:0]    b;
        logic [OFFSET_STRUCT_WIDTH-1:0] off;
        b = '0;
        for (int i = 0; i < NUM_SUB_PACKETS; i++) begin
            off = mem_off[s*4+i][a];
            b[i*128      +: OFFSET_WIDTH]  = off[0 +: OFFSET_WIDTH];
            b[i*128 + 32 +: OFFSET_WIDTH]  = off[OFFSET_WIDTH +: OFFSET_WIDTH];
            b[i*128 + 64 +: OFFSET_WIDTH]  = off[2*OFFSET_WIDTH +: OFFSET_WIDTH];
            b[i*128 + 96 +: ELEMENT_WIDTH] = mem_el[s*4+i][a];
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [AXIS_TDATA_WIDTH-1:0] got,
                         input logic [AXIS_TDATA_WIDTH-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: read ordering, credit, scoreboard pops, stall stability, done pulses.
    initial begin
        logic                        prev_stall = 1'b0;
        logic [AXIS_TDATA_WIDTH-1:0] prev_data  = '0;
        logic                        prev_last  = 1'b0;
        logic [NUM_INIT_STEPS-1:0]   one        = 1;
        exp_t                        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("tvalid_hold", tvalid, 1);
                    check("tdata_hold", tdata, prev_data);
                    check("tlast_hold", tlast, prev_last);
                end
                if (rd_en != '0) begin
                    check("credit", (issued - accepted) < D, 1);
                    if (rd_npc == 0 || rd_idx >= NUM_INIT_STEPS * rd_npc) begin
                        check("rd_unexpected", 1, 0);
                    end else begin
                        check("rd_en", rd_en, one << (rd_idx / rd_npc));
                        check("rd_addr", rd_addr, rd_idx % rd_npc);
                    end
                    rd_idx++;
                    issued++;
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", tdata, e.d);
`ifdef MD_DUMP_TLAST_EN
                        check("tlast", tlast, e.last);
`endif
                    end
                    accepted++;
                    last_pop_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_last  = tlast;
            end
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic issue_start(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        npc   = PARTICLE_ID_WIDTH'(n);
        for (int s = 0; s < NUM_INIT_STEPS; s++) begin
            for (int a = 0; a < n; a++) begin
                exp_q.push_back('{d: exp_beat(s, a),
                                  last: (s == NUM_INIT_STEPS-1) && (a == n-1)});
            end
        end
        rd_npc = n;
        rd_idx = 0;
        @(negedge clk);
        #1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        npc   = PARTICLE_ID_WIDTH'($urandom_range(1, 7));
    endtask

    task automatic run_dump(input int n, input bit disturb);
        int base_acc;
        int base_done;
        int t;
        base_acc  = accepted;
        base_done = done_cnt;
        issue_start(n);
        @(negedge clk);
        #1;
        if (n > 0) check("busy_on", busy, 1);
        if (disturb) begin
            repeat (5) @(posedge clk);
            #1;
            start = 1'b1;
            npc   = 8'd2;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        t = 0;
        while (done_cnt == base_done && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) check("done_timeout", 0, 1);
        // done follows DONE entry: the cycle after start for npc=0,
        // otherwise one DRAIN cycle after the final transfer edge.
        if (n == 0) check("done_lat_npc0", done_cyc - start_cyc, 1);
        else        check("done_lat", done_cyc - last_pop_cyc, 2);
        repeat (5) @(negedge clk);
        #1;
        check("done_once", done_cnt - base_done, 1);
        check("beat_count", accepted - base_acc, NUM_INIT_STEPS * n);
        check("queue_empty", exp_q.size(), 0);
        check("busy_off", busy, 0);
    endtask

    initial begin
        int base_acc;
        int t;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc;
        int t;
        for (int c = 0; c < NUM_CELLS; c++) begin
            for (int a = 0; a < 8; a++) begin
                mem_off[c][a] = OFFSET_STRUCT_WIDTH'({$urandom(), $urandom(), $urandom()});
                mem_el[c][a]  = ELEMENT_WIDTH'($urandom());
            end
        end
        rst   = 1'b1;
        start = 1'b0;
        npc   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_step", step, 0);
        check("rst_tdata", tdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_dump(3, 1'b0);
        rnd_ready = 1;
        run_dump(5, 1'b0);
        run_dump(0, 1'b0);
        run_dump(4, 1'b1);

        // Reset in the middle of a dump, after 7 accepted beats.
        base_acc = accepted;
        issue_start(4);
        t = 0;
        while ((accepted - base_acc) < 7 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) check("seven_beats_timeout", 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        issued   = 0;
        accepted = 0;
        rd_npc   = 0;
        rd_idx   = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_tvalid", tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_done", done, 0);
        repeat (4) @(posedge clk);
        run_dump(4, 1'b0);

        run_dump(2, 1'b0);
        rnd_ready = 0;
        run_dump(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
